// File: rtl/mmio_display_bank.sv
// Memory-mapped register bank feeding the 7-segment display, with manual or timed-scan entry select.
// Define MMIO_DISPLAY_READBACK_EN to build the one-cycle-latency CPU readback port.
module mmio_display_bank #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 16,
  parameter int          DATA_W    = 16,
  parameter int          DWELL     = 50_000_000,
  parameter int          SEL_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  input  logic              mem_write,
  input  logic              mem_read,
  output logic [31:0]       read_data,
  output logic              read_valid,
  input  logic [SEL_W-1:0]  sw,
  input  logic              auto_mode,
  output logic [DATA_W-1:0] value,
  output logic [SEL_W-1:0]  index,
  output logic              hit
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  logic [DATA_W-1:0] entries [DEPTH];
  logic [SEL_W-1:0]  entry_sel;
  logic [CNT_W-1:0]  dwell_cnt;
  logic              unused_bits;

  assign hit         = (address >= BASE_ADDR) && ({1'b0, address} < WIN_END);
  assign entry_sel   = address[SEL_W+1:2];
  assign unused_bits = ^write_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (mem_write && hit) begin
      entries[entry_sel] <= write_data[DATA_W-1:0];
    end
  end

  // Dwell timer is a down-counter held at its reload value in manual mode,
  // so entering auto mode always starts a full dwell on the current index.
  always_ff @(posedge clk) begin
    if (rst) begin
      index     <= '0;
      dwell_cnt <= DWELL_LAST;
    end else if (auto_mode) begin
      if (dwell_cnt == '0) begin
        index     <= index + SEL_W'(1);
        dwell_cnt <= DWELL_LAST;
      end else begin
        dwell_cnt <= dwell_cnt - CNT_W'(1);
      end
    end else begin
      index     <= sw;
      dwell_cnt <= DWELL_LAST;
    end
  end

  assign value = entries[index];

`ifdef MMIO_DISPLAY_READBACK_EN
  // Reads sample the array before this edge's write, so a same-cycle
  // write/read of one entry returns the old contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= mem_read && hit;
      if (mem_read && hit) read_data <= 32'(entries[entry_sel]);
    end
  end
`else
  logic unused_read;
  assign unused_read = mem_read;
  assign read_data   = 32'd0;
  assign read_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_display_bank.sv
// Randomized and directed bench for mmio_display_bank against a behavioural model.
// Readback expectations follow MMIO_DISPLAY_READBACK_EN as the RTL is built.
module tb_mmio_display_bank;

`ifdef MMIO_DISPLAY_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address, write_data, read_data;
  logic        mem_write, mem_read, read_valid;
  logic [3:0]  sw, index;
  logic        auto_mode, hit;
  logic [15:0] value;

  mmio_display_bank #(
    .BASE_ADDR(32'h0000_1000), .DEPTH(16), .DATA_W(16), .DWELL(4)
  ) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data),
    .read_valid(read_valid), .sw(sw), .auto_mode(auto_mode),
    .value(value), .index(index), .hit(hit)
  );

  always #5 clk = ~clk;

  logic [15:0] m_mem [16];
  int          m_idx, m_ticks;
  logic [31:0] m_rd;
  logic        m_rv;
  int          n_total = 0, n_bad = 0;
  bit          rv_seen = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit in_window(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h1040);
  endfunction

  // One clock: check decode, take the edge, advance the model, compare outputs.
  task automatic tick();
    bit          h;
    logic [31:0] off;
    int          n;
    #1;
    h = in_window(address);
    check_val("hit", 32'(hit), 32'(h));
    @(posedge clk);
    #1;
    off = address - 32'h1000;
    n   = int'(off[5:2]);
    if (rst) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_idx = 0; m_ticks = 0; m_rd = '0; m_rv = 1'b0;
    end else begin
      m_rv = RB && mem_read && h;
      if (m_rv) m_rd = {16'h0, m_mem[n]};
      if (mem_write && h) m_mem[n] = write_data[15:0];
      if (auto_mode) begin
        m_ticks++;
        if (m_ticks % 4 == 0) m_idx = (m_idx + 1) % 16;
      end else begin
        m_ticks = 0;
        m_idx   = int'(sw);
      end
    end
    check_val("value", 32'(value), 32'(m_mem[m_idx]));
    check_val("index", 32'(index), 32'(m_idx));
    check_val("read_data", read_data, m_rd);
    check_val("read_valid", 32'(read_valid), 32'(m_rv));
    if (read_valid) rv_seen = 1'b1;
  endtask

  int exp_seq [15];

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    m_idx = 0; m_ticks = 0; m_rd = '0; m_rv = 1'b0;
    exp_seq = '{14, 14, 14, 15, 15, 15, 15, 0, 0, 0, 0, 1, 1, 1, 1};
    rst = 1'b1; address = 32'h0; write_data = 32'h0; mem_write = 1'b0;
    mem_read = 1'b0; sw = 4'd0; auto_mode = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_rv", 32'(read_valid), 32'd0);
    check_val("rst_idx", 32'(index), 32'd0);

    for (int i = 0; i < 16; i++) begin
      sw = 4'(i);
      tick();
      check_val("sweep_idx", 32'(index), 32'(i));
      check_val("sweep_val", 32'(value), 32'h0);
    end

    address = 32'h1008; write_data = 32'hDEAD_BEEF; mem_write = 1'b1; sw = 4'd2;
    tick();
    mem_write = 1'b0;
    check_val("beef_val", 32'(value), 32'hBEEF);
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    check_val("beef_rd", read_data, RB ? 32'h0000_BEEF : 32'h0);
    check_val("beef_rv", 32'(read_valid), 32'(RB));
    tick();
    check_val("beef_rv_drop", 32'(read_valid), 32'd0);

    address = 32'h0FFC; write_data = 32'h1234; mem_write = 1'b1; sw = 4'd15;
    #1 check_val("miss_lo_hit", 32'(hit), 32'd0);
    tick();
    address = 32'h1040;
    #1 check_val("miss_hi_hit", 32'(hit), 32'd0);
    tick();
    mem_write = 1'b0;
    tick();
    check_val("miss_val", 32'(value), 32'h0);
    address = 32'h103F; mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    check_val("edge_val", 32'(value), 32'h1234);

    sw = 4'd14;
    tick();
    auto_mode = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      check_val("scan_idx", 32'(index), 32'(exp_seq[k]));
    end
    auto_mode = 1'b0; sw = 4'd7;
    tick();
    check_val("manual_back", 32'(index), 32'd7);

    address = 32'h1004; write_data = 32'hAAAA; mem_write = 1'b1;
    tick();
    write_data = 32'h5555; mem_read = 1'b1;
    tick();
    mem_write = 1'b0;
    check_val("rw_old", read_data, RB ? 32'hAAAA : 32'h0);
    tick();
    mem_read = 1'b0;
    check_val("rw_new", read_data, RB ? 32'h5555 : 32'h0);

    auto_mode = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    rst = 1'b1; address = 32'h1000; write_data = 32'h7777; mem_write = 1'b1;
    tick();
    rst = 1'b0; mem_write = 1'b0;
    check_val("rst_scan_idx", 32'(index), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("rst_dwell", 32'(index), (k < 3) ? 32'd0 : 32'd1);
    end
    auto_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sw = 4'(i);
      tick();
      check_val("rst_clear", 32'(value), 32'h0);
    end

    for (int c = 0; c < 400; c++) begin
      rst        = ($urandom_range(0, 49) == 0);
      address    = 32'h0FF0 + $urandom_range(0, 32'h5F);
      write_data = $urandom;
      mem_write  = ($urandom_range(0, 2) == 0);
      mem_read   = ($urandom_range(0, 2) == 0);
      sw         = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) auto_mode = ~auto_mode;
      tick();
    end

    check_val("rv_seen", 32'(rv_seen), 32'(RB));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
